pipe_cla_addsub: RTL and testbench



---
 rtl/pipe_cla_addsub_if.sv | 29 ++
 rtl/pipe_cla_addsub.sv | 147 ++++++++++++++
 tb/tb_pipe_cla_addsub.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_cla_addsub_if.sv
// Operand/result handshake bundle for pipe_cla_addsub.
// master drives operands and consumes results; slave is the adder.
`timescale 1ns/1ps
interface pipe_cla_addsub_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             c_out;
  logic             ovf;
  logic             zero;

  modport master (
    output in_valid, a, b, c_in, sub, out_ready,
    input  in_ready, out_valid, sum, c_out, ovf, zero
  );

  modport slave (
    input  in_valid, a, b, c_in, sub, out_ready,
    output in_ready, out_valid, sum, c_out, ovf, zero
  );
endinterface

// File: rtl/pipe_cla_addsub.sv
// Pipelined CLA adder/subtractor, one CHUNK-bit stage per register, global stall.
// Define PIPE_CLA_SAT_EN to saturate the result to the signed limit on overflow.
`timescale 1ns/1ps
module pipe_cla_addsub #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CHUNK = 8
) (
  input logic              clk,
  input logic              rst_n,
  pipe_cla_addsub_if.slave bus
);
  localparam int unsigned NSTAGE = WIDTH / CHUNK;
  localparam int unsigned NSLICE = CHUNK / 4;

  // 4-bit CLA slice: returns {group G, group P, sum[3:0]}.
  function automatic logic [5:0] cla4(input logic [3:0] x, input logic [3:0] y,
                                      input logic ci);
    logic [3:0] g, p, c;
    logic       gg;
    g    = x & y;
    p    = x ^ y;
    c[0] = ci;
    c[1] = g[0] | (p[0] & ci);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    gg   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    return {gg, &p, p ^ c};
  endfunction

  // One chunk: slices feed a look-ahead carry unit whose carries are flat sums of products.
  function automatic logic [CHUNK:0] add_chunk(input logic [CHUNK-1:0] x,
                                               input logic [CHUNK-1:0] y, input logic ci);
    logic [NSLICE:0]   c;
    logic [NSLICE-1:0] gs, ps;
    logic [CHUNK-1:0]  s;
    logic [5:0]        r;
    logic              acc, pr;
    for (int j = 0; j < int'(NSLICE); j++) begin
      r     = cla4(x[4*j +: 4], y[4*j +: 4], 1'b0);
      gs[j] = r[5];
      ps[j] = r[4];
    end
    c[0] = ci;
    for (int j = 1; j <= int'(NSLICE); j++) begin
      acc = 1'b0;
      for (int i = 0; i < j; i++) begin
        pr = 1'b1;
        for (int m = i + 1; m < j; m++) pr = pr & ps[m];
        acc = acc | (gs[i] & pr);
      end
      pr = 1'b1;
      for (int m = 0; m < j; m++) pr = pr & ps[m];
      c[j] = acc | (ci & pr);
    end
    for (int j = 0; j < int'(NSLICE); j++) begin
      r          = cla4(x[4*j +: 4], y[4*j +: 4], c[j]);
      s[4*j +: 4] = r[3:0];
    end
    return {c[NSLICE], s};
  endfunction

  logic [NSTAGE-1:0] vld_q, vld_d, cy_q, cy_d;
  logic [NSTAGE-1:0] src_v, src_c;
  logic [WIDTH-1:0]  a_q   [NSTAGE];
  logic [WIDTH-1:0]  b_q   [NSTAGE];
  logic [WIDTH-1:0]  s_q   [NSTAGE];
  logic [WIDTH-1:0]  s_d   [NSTAGE];
  logic [WIDTH-1:0]  src_a [NSTAGE];
  logic [WIDTH-1:0]  src_b [NSTAGE];
  logic [WIDTH-1:0]  src_s [NSTAGE];
  logic              ovf_q, ovf_d, zero_q, zero_d;
  logic              adv;

  assign adv = !vld_q[NSTAGE-1] || bus.out_ready;

  always_comb begin
    logic [CHUNK:0]   r;
    logic [WIDTH-1:0] fs;
    logic             msb_ci;
    r      = '0;
    fs     = '0;
    msb_ci = 1'b0;
    // Stage 0 takes the live inputs; later stages take the previous stage's registers.
    src_v[0] = bus.in_valid;
    src_a[0] = bus.a;
    src_b[0] = bus.sub ? ~bus.b : bus.b;
    src_c[0] = bus.sub | bus.c_in;
    src_s[0] = '0;
    for (int k = 1; k < int'(NSTAGE); k++) begin
      src_v[k] = vld_q[k-1];
      src_a[k] = a_q[k-1];
      src_b[k] = b_q[k-1];
      src_c[k] = cy_q[k-1];
      src_s[k] = s_q[k-1];
    end
    for (int k = 0; k < int'(NSTAGE); k++) begin
      r                       = add_chunk(src_a[k][k*CHUNK +: CHUNK], src_b[k][k*CHUNK +: CHUNK],
                                          src_c[k]);
      s_d[k]                  = src_s[k];
      s_d[k][k*CHUNK +: CHUNK] = r[CHUNK-1:0];
      cy_d[k]                 = r[CHUNK];
      vld_d[k]                = src_v[k];
    end
    fs     = s_d[NSTAGE-1];
    msb_ci = src_a[NSTAGE-1][WIDTH-1] ^ src_b[NSTAGE-1][WIDTH-1] ^ fs[WIDTH-1];
    ovf_d  = cy_d[NSTAGE-1] ^ msb_ci;
`ifdef PIPE_CLA_SAT_EN
    // On overflow both operand signs agree, so a's sign gives the direction.
    if (ovf_d) begin
      fs = src_a[NSTAGE-1][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
`endif
    s_d[NSTAGE-1] = fs;
    zero_d        = (fs == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= '0;
      cy_q   <= '0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
      for (int k = 0; k < int'(NSTAGE); k++) s_q[k] <= '0;
      for (int k = 0; k < int'(NSTAGE) - 1; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
      end
    end else if (adv) begin
      vld_q  <= vld_d;
      cy_q   <= cy_d;
      ovf_q  <= ovf_d;
      zero_q <= zero_d;
      for (int k = 0; k < int'(NSTAGE); k++) s_q[k] <= s_d[k];
      for (int k = 0; k < int'(NSTAGE) - 1; k++) begin
        a_q[k] <= src_a[k];
        b_q[k] <= src_b[k];
      end
    end
  end

  assign bus.in_ready  = adv;
  assign bus.out_valid = vld_q[NSTAGE-1];
  assign bus.sum       = s_q[NSTAGE-1];
  assign bus.c_out     = cy_q[NSTAGE-1];
  assign bus.ovf       = ovf_q;
  assign bus.zero      = zero_q;
endmodule

// File: tb/tb_pipe_cla_addsub.sv
// Scoreboard bench for pipe_cla_addsub: 32/8 four-stage and 16/16 single-stage instances.
`timescale 1ns/1ps
module tb_pipe_cla_addsub;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pipe_cla_addsub_if #(.WIDTH(32)) bus ();
  pipe_cla_addsub_if #(.WIDTH(16)) bus16 ();

  pipe_cla_addsub #(.WIDTH(32), .CHUNK(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  pipe_cla_addsub #(.WIDTH(16), .CHUNK(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16));

  typedef struct {
    logic [31:0] sum;
    logic        c;
    logic        o;
    logic        z;
    int          acc;
    bit          lat;
  } exp_t;

  exp_t q32[$];
  exp_t q16[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   n_pop32 = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor for the 4-stage instance: pops on consume, checks hold/backpressure on stall.
  logic [63:0] held;
  bit          stalled = 0;
  always @(negedge clk) begin : mon32
    exp_t e;
    if (!rst_n) begin
      stalled = 0;
    end else if (bus.out_valid && bus.out_ready) begin
      stalled = 0;
      if (q32.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected32: got sum 0x%0h with nothing pending", bus.sum);
      end else begin
        e = q32.pop_front();
        check("sum32", 64'(bus.sum), 64'(e.sum));
        check("c_out32", 64'(bus.c_out), 64'(e.c));
        check("ovf32", 64'(bus.ovf), 64'(e.o));
        check("zero32", 64'(bus.zero), 64'(e.z));
        if (e.lat) check("latency32", 64'(cyc - e.acc), 64'd3);
        n_pop32++;
      end
    end else if (bus.out_valid) begin
      check("in_ready_stall", 64'(bus.in_ready), 64'd0);
      if (stalled) check("hold32", {29'd0, bus.sum, bus.c_out, bus.ovf, bus.zero}, held);
      held    = {29'd0, bus.sum, bus.c_out, bus.ovf, bus.zero};
      stalled = 1;
    end else begin
      stalled = 0;
    end
  end

  always @(negedge clk) begin : mon16
    exp_t e;
    if (rst_n && bus16.out_valid && bus16.out_ready) begin
      if (q16.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected16: got sum 0x%0h with nothing pending", bus16.sum);
      end else begin
        e = q16.pop_front();
        check("sum16", 64'(bus16.sum), 64'(e.sum));
        check("c_out16", 64'(bus16.c_out), 64'(e.c));
        check("ovf16", 64'(bus16.ovf), 64'(e.o));
        check("zero16", 64'(bus16.zero), 64'(e.z));
        if (e.lat) check("latency16", 64'(cyc - e.acc), 64'd0);
      end
    end
  end

  task automatic send32(input logic [31:0] a, input logic [31:0] b, input logic ci,
                        input logic s, input logic [31:0] es, input logic ec, input logic eo,
                        input logic ez, input bit lat);
    bit   ok = 0;
    exp_t e;
    bus.a        = a;
    bus.b        = b;
    bus.c_in     = ci;
    bus.sub      = s;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      ok = bus.in_ready;
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    if (!ok) begin
      n_cmp++;
      n_bad++;
      $display("FAIL accept32: in_ready stayed 0, expected acceptance");
    end else begin
      e.sum = es; e.c = ec; e.o = eo; e.z = ez; e.acc = cyc; e.lat = lat;
      q32.push_back(e);
    end
  endtask

  task automatic send16(input logic [15:0] a, input logic [15:0] b, input logic ci,
                        input logic s, input logic [15:0] es, input logic ec, input logic eo,
                        input logic ez);
    bit   ok = 0;
    exp_t e;
    bus16.a        = a;
    bus16.b        = b;
    bus16.c_in     = ci;
    bus16.sub      = s;
    bus16.in_valid = 1'b1;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      ok = bus16.in_ready;
      @(posedge clk);
      #1;
    end
    bus16.in_valid = 1'b0;
    if (!ok) begin
      n_cmp++;
      n_bad++;
      $display("FAIL accept16: in_ready stayed 0, expected acceptance");
    end else begin
      e.sum = 32'(es); e.c = ec; e.o = eo; e.z = ez; e.acc = cyc; e.lat = 1;
      q16.push_back(e);
    end
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 100 && (q32.size() != 0 || q16.size() != 0); i++) begin
      @(posedge clk);
      #1;
    end
    check(name, 64'(q32.size() + q16.size()), 64'd0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1);
  end

  initial begin : stim
    int base;
    rst_n = 1'b0;
    bus.in_valid = 0; bus.a = '0; bus.b = '0; bus.c_in = 0; bus.sub = 0; bus.out_ready = 1;
    bus16.in_valid = 0; bus16.a = '0; bus16.b = '0; bus16.c_in = 0; bus16.sub = 0;
    bus16.out_ready = 1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_sum", 64'(bus.sum), 64'd0);
    check("rst_flags", {61'd0, bus.c_out, bus.ovf, bus.zero}, 64'd0);
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("rst_out_valid16", 64'(bus16.out_valid), 64'd0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed vectors, back to back, each with a 4-edge latency check.
    send32(32'hFFFF_FFFF, 32'h0000_0001, 0, 0, 32'h0000_0000, 1, 0, 1, 1);
`ifdef PIPE_CLA_SAT_EN
    send32(32'h8000_0000, 32'h0000_0001, 0, 1, 32'h8000_0000, 1, 1, 0, 1);
    send32(32'h7FFF_FFFF, 32'h0000_0001, 0, 0, 32'h7FFF_FFFF, 0, 1, 0, 1);
`else
    send32(32'h8000_0000, 32'h0000_0001, 0, 1, 32'h7FFF_FFFF, 1, 1, 0, 1);
    send32(32'h7FFF_FFFF, 32'h0000_0001, 0, 0, 32'h8000_0000, 0, 1, 0, 1);
`endif
    send32(32'h0000_0005, 32'h0000_0007, 0, 1, 32'hFFFF_FFFE, 0, 0, 0, 1);
    send32(32'h1234_5678, 32'h0FED_CBA8, 1, 0, 32'h2222_2221, 0, 0, 0, 1);
    send32(32'h0000_000A, 32'h0000_0003, 1, 1, 32'h0000_0007, 1, 0, 0, 1);
    drain("drain_directed");

    // Streaming with a 5-cycle stall after the second result.
    base = n_pop32;
    fork
      begin
        for (int i = 0; i < 8; i++)
          send32(32'(i), 32'(i * 256), 0, 0, 32'(i * 257), 0, 0, (i == 0), 0);
      end
      begin
        for (int j = 0; j < 100 && n_pop32 < base + 2; j++) begin
          @(negedge clk);
          #1;
        end
        @(posedge clk);
        #1 bus.out_ready = 0;
        repeat (5) @(posedge clk);
        #1 bus.out_ready = 1;
      end
    join
    drain("drain_stream");
    check("stream_count", 64'(n_pop32 - base), 64'd8);

    // Reset with results in flight and one presented under backpressure.
    bus.out_ready = 0;
    send32(32'h1, 32'h1, 0, 0, 32'h2, 0, 0, 0, 0);
    send32(32'h2, 32'h2, 0, 0, 32'h4, 0, 0, 0, 0);
    send32(32'h3, 32'h3, 0, 0, 32'h6, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    check("pre_reset_valid", 64'(bus.out_valid), 64'd1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("reset_out_valid", 64'(bus.out_valid), 64'd0);
    check("reset_sum", 64'(bus.sum), 64'd0);
    check("reset_flags", {61'd0, bus.c_out, bus.ovf, bus.zero}, 64'd0);
    q32.delete();
    bus.out_ready = 1;
    base = n_pop32;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    check("no_stale_valid", 64'(bus.out_valid), 64'd0);
    check("no_stale_pop", 64'(n_pop32 - base), 64'd0);
    send32(32'h1234_5678, 32'h0FED_CBA8, 1, 0, 32'h2222_2221, 0, 0, 0, 1);
    drain("drain_post_reset");

    // Single-stage instance: result on the accepting edge.
    send16(16'hABCD, 16'h1234, 1, 0, 16'hBE02, 0, 0, 0);
    send16(16'hFFFF, 16'h0001, 0, 0, 16'h0000, 1, 0, 1);
`ifdef PIPE_CLA_SAT_EN
    send16(16'h8000, 16'h0001, 0, 1, 16'h8000, 1, 1, 0);
`else
    send16(16'h8000, 16'h0001, 0, 1, 16'h7FFF, 1, 1, 0);
`endif
    drain("drain16");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
